// File: rtl/instr_prefetch_unit_pkg.sv
// Shared types and constants for the instruction prefetch front-end.
package instr_prefetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [INSTR_W-1:0] NOP = 32'h0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'd3;
  endfunction

endpackage

// File: rtl/instr_prefetch_unit_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} pairs; flush empties it in one cycle.
module instr_prefetch_unit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       push_data_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  // Pointers are AW bits wide, so wrap-around by DEPTH is free.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !reset && !flush_i) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/instr_prefetch_unit.sv
// Fetch front-end: single-outstanding memory read FSM feeding a prefetch FIFO for the IF stage.
// Handshake: mem_req/mem_addr are registered and held until a cycle with mem_ready=1 completes them.
module instr_prefetch_unit
  import instr_prefetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instru,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output state_e      dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e       state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic         mem_req_q, mem_req_d;
  logic         push, pop, room, full, empty;
  logic [CW-1:0] count, count_next;
  fetch_entry_t push_entry, head;

  assign pop        = !empty && !stall && !redirect;
  assign push       = (state_q == S_REQ) && mem_ready && !redirect && !full;
  assign count_next = redirect ? '0 : count + CW'(push) - CW'(pop);
  assign room       = (count_next < CW'(DEPTH));
  assign push_entry = '{pc: fetch_pc_q, instr: mem_rdata};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    if (redirect) fetch_pc_d = align_pc(redirect_pc);
    case (state_q)
      S_IDLE: begin
        if (!redirect && room) begin
          state_d    = S_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end
      end
      S_REQ: begin
        if (redirect) begin
          // A redirect racing a response just drops it; otherwise wait it out.
          if (mem_ready) begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (mem_ready) begin
          fetch_pc_d = fetch_pc_q + PC_INC;
          if (room) begin
            mem_addr_d = fetch_pc_q + PC_INC;
          end else begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (mem_ready) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  instr_prefetch_unit_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (redirect),
    .push_data_i (push_entry),
    .head_o      (head),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign if_valid    = !empty;
  assign if_instru   = empty ? NOP : head.instr;
  assign if_pc       = empty ? 32'h0 : head.pc;
  assign if_pc_plus4 = if_pc + PC_INC;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: directed phases plus random traffic against a scoreboard model.
module tb_instr_prefetch_unit;
  import instr_prefetch_unit_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instru, if_pc, if_pc_plus4;
  state_e      dbg_state;

  always #5 clk = ~clk;

  instr_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .if_valid    (if_valid),
    .if_instru   (if_instru),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int passed = 0;
  logic [31:0] exp_q[$];       // PCs the IF stage should see, oldest first
  logic [31:0] exp_fetch_pc;   // address the next fresh request must carry
  bit          busy, stale, hold_prev;
  int          wait_cnt;
  logic [31:0] prev_addr;
  int          lat_min = 0, lat_max = 0;
  bit          did;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic reset_seq(input int n, input bit rdy);
    @(negedge clk);
    reset = 1'b1; mem_ready = rdy; mem_rdata = $urandom;
    redirect = 1'b0; stall = 1'b0;
    repeat (n) @(negedge clk);
    mem_ready = 1'b0;
    exp_q.delete();
    exp_fetch_pc = RST_PC;
    busy = 0; stale = 0; hold_prev = 0; wait_cnt = 0;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_instru", if_instru, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_pc_plus4", if_pc_plus4, 32'd4);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    reset = 1'b0;
  endtask

  // rmode: 0 no redirect, 1 redirect, 2 only with a response this cycle,
  // 3 only while a request waits without a response.
  task automatic cycle(input int rmode, input logic [31:0] rpc, input bit st, output bit did_redir);
    bit rdy, redir, pop;
    @(negedge clk);
    if (hold_prev) begin
      chk("req_held", 32'(mem_req), 32'd1);
      chk("addr_held", mem_addr, prev_addr);
    end
    chk("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("if_pc", if_pc, exp_q[0]);
      chk("if_instru", if_instru, mem_word(exp_q[0]));
      chk("if_pc_plus4", if_pc_plus4, exp_q[0] + 32'd4);
    end
    if (exp_q.size() == DEPTH) chk("req_off_when_full", 32'(mem_req), 32'd0);
    if (mem_req && !busy) begin
      chk("req_addr", mem_addr, exp_fetch_pc);
      busy = 1; stale = 0;
      wait_cnt = $urandom_range(lat_max, lat_min);
    end
    rdy = busy && (wait_cnt == 0);
    if (busy && !rdy) wait_cnt--;
    case (rmode)
      1:       redir = 1'b1;
      2:       redir = rdy;
      3:       redir = busy && !rdy;
      default: redir = 1'b0;
    endcase
    did_redir   = redir;
    mem_ready   = rdy;
    mem_rdata   = rdy ? mem_word(mem_addr) : $urandom;
    redirect    = redir;
    redirect_pc = rpc;
    stall       = st;
    // Effects of this cycle at the coming rising edge.
    pop       = (exp_q.size() != 0) && !st && !redir;
    hold_prev = mem_req && !rdy;
    prev_addr = mem_addr;
    if (redir) begin
      exp_q.delete();
      exp_fetch_pc = rpc & ~32'd3;
      if (busy) stale = 1;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (rdy && !stale) begin
        exp_q.push_back(exp_fetch_pc);
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
    end
    if (rdy) busy = 0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int r;
    logic [31:0] rpc;

    reset_seq(3, 1'b0);

    // Zero-wait memory: one fetch and one delivery per cycle, PC wraps past 2^32.
    lat_min = 0; lat_max = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 32'h0, 1'b0, did);
      chk("steady_req", 32'(mem_req), 32'd1);
      if (i >= 1) chk("steady_valid", 32'(if_valid), 32'd1);
    end

    // Three-cycle latency: request held steady while waiting.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 16; i++) cycle(0, 32'h0, 1'b0, did);

    // Stall fills the buffer and fetching stops; release drains it in order.
    lat_min = 0; lat_max = 0;
    for (int i = 0; i < 10; i++) cycle(0, 32'h0, 1'b1, did);
    chk("stall_req_off", 32'(mem_req), 32'd0);
    chk("stall_valid", 32'(if_valid), 32'd1);
    for (int i = 0; i < 8; i++) cycle(0, 32'h0, 1'b0, did);

    // Redirect while a request is in flight: stale response must vanish.
    lat_min = 2; lat_max = 2;
    did = 0;
    for (int k = 0; k < 30 && !did; k++) cycle(3, 32'h100, 1'b0, did);
    chk("bound_redir_inflight", 32'(did), 32'd1);
    for (int i = 0; i < 12; i++) cycle(0, 32'h0, 1'b0, did);

    // Redirect coinciding with a response.
    lat_min = 0; lat_max = 0;
    did = 0;
    for (int k = 0; k < 30 && !did; k++) cycle(2, 32'h203, 1'b0, did);
    chk("bound_redir_ready", 32'(did), 32'd1);
    for (int i = 0; i < 6; i++) cycle(0, 32'h0, 1'b0, did);

    // Redirect while stalled with a full buffer: flush wins over hold.
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 12; i++) cycle(0, 32'h0, 1'b1, did);
    cycle(1, 32'h300, 1'b1, did);
    for (int i = 0; i < 10; i++) cycle(0, 32'h0, 1'b0, did);

    // Random traffic: latency, stalls, redirects (misaligned and near-wrap targets).
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      r   = $urandom_range(99, 0);
      rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
      cycle((r < 4) ? 1 : 0, rpc, ($urandom_range(99, 0) < 25), did);
    end

    // Reset in the middle of an outstanding request, with a response during reset.
    lat_min = 3; lat_max = 3;
    did = 0;
    for (int k = 0; k < 20 && !did; k++) begin
      cycle(0, 32'h0, 1'b0, did);
      did = busy && (wait_cnt > 0);
    end
    chk("bound_mid_req", 32'(did), 32'd1);
    reset_seq(1, 1'b1);
    lat_min = 0; lat_max = 2;
    for (int i = 0; i < 60; i++) cycle(0, 32'h0, ($urandom_range(99, 0) < 20), did);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
